// File: rtl/dot_square_detect.sv
// Bounding-rectangle detector: scans a raster pixel stream for a key colour and
// reports the half-open, signed rectangle of all matches at frame end.
module dot_square_detect #(
  parameter int pHdisplayWidth = 11,
  parameter int pVdisplayWidth = 11,
  parameter int pColorDepth    = 16
) (
  input  logic                                     iClk,
  input  logic                                     iRst,
  input  logic [pColorDepth-1:0]                   iPixel,
  input  logic [pColorDepth-1:0]                   iKeyColor,
  input  logic [pHdisplayWidth-1:0]                iHpos,
  input  logic [pVdisplayWidth-1:0]                iVpos,
  input  logic                                     iPixelVd,
  input  logic                                     iFrameStart,
  input  logic                                     iFrameEnd,
  output logic signed [pHdisplayWidth:0]           oDLeftX,
  output logic signed [pHdisplayWidth:0]           oDRightX,
  output logic signed [pVdisplayWidth:0]           oDTopY,
  output logic signed [pVdisplayWidth:0]           oDUnderY,
  output logic [pHdisplayWidth+pVdisplayWidth-1:0] oCount,
  output logic                                     oFound,
  output logic                                     oVd,
  input  logic                                     iRdy,
  output logic                                     oOverrun
);

  localparam int HW = pHdisplayWidth;
  localparam int VW = pVdisplayWidth;
  localparam int CW = pHdisplayWidth + pVdisplayWidth;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        r_state, w_state_next;
  logic [HW-1:0] r_min_x, r_max_x, w_min_x_next, w_max_x_next;
  logic [VW-1:0] r_min_y, r_max_y, w_min_y_next, w_max_y_next;
  logic [CW-1:0] r_count, w_count_next;
  logic          r_hit, w_hit_next;
  logic          w_load;

  logic          w_match;
  logic [HW-1:0] w_cur_min_x, w_cur_max_x, w_new_min_x, w_new_max_x;
  logic [VW-1:0] w_cur_min_y, w_cur_max_y, w_new_min_y, w_new_max_y;
  logic [CW-1:0] w_cur_count, w_new_count;
  logic          w_cur_hit;
  logic [HW:0]   w_right_x;
  logic [VW:0]   w_under_y;

  assign w_match = iPixelVd && (iPixel == iKeyColor);

  // Running accumulators with this cycle's pixel folded in
  assign w_cur_min_x = (w_match && (iHpos < r_min_x)) ? iHpos : r_min_x;
  assign w_cur_max_x = (w_match && (iHpos > r_max_x)) ? iHpos : r_max_x;
  assign w_cur_min_y = (w_match && (iVpos < r_min_y)) ? iVpos : r_min_y;
  assign w_cur_max_y = (w_match && (iVpos > r_max_y)) ? iVpos : r_max_y;
  assign w_cur_count = (w_match && (r_count != '1))
                       ? r_count + {{(CW-1){1'b0}}, 1'b1} : r_count;
  assign w_cur_hit   = r_hit | w_match;

  // Freshly initialised accumulators with this cycle's pixel folded in
  assign w_new_min_x = w_match ? iHpos : '1;
  assign w_new_max_x = w_match ? iHpos : '0;
  assign w_new_min_y = w_match ? iVpos : '1;
  assign w_new_max_y = w_match ? iVpos : '0;
  assign w_new_count = w_match ? {{(CW-1){1'b0}}, 1'b1} : '0;

  // One extra bit so that position 2^W-1 yields 2^W exclusive edge
  assign w_right_x = {1'b0, w_cur_max_x} + {{HW{1'b0}}, 1'b1};
  assign w_under_y = {1'b0, w_cur_max_y} + {{VW{1'b0}}, 1'b1};

  always_comb begin
    w_state_next = r_state;
    w_min_x_next = r_min_x;
    w_max_x_next = r_max_x;
    w_min_y_next = r_min_y;
    w_max_y_next = r_max_y;
    w_count_next = r_count;
    w_hit_next   = r_hit;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (iFrameStart) begin
          w_state_next = SCAN;
          w_min_x_next = w_new_min_x;
          w_max_x_next = w_new_max_x;
          w_min_y_next = w_new_min_y;
          w_max_y_next = w_new_max_y;
          w_count_next = w_new_count;
          w_hit_next   = w_match;
        end
      end
      SCAN: begin
        if (iFrameEnd) begin
          // The pixel went to the closing frame, so the next frame starts empty
          w_load       = 1'b1;
          w_state_next = iFrameStart ? SCAN : IDLE;
          w_min_x_next = '1;
          w_max_x_next = '0;
          w_min_y_next = '1;
          w_max_y_next = '0;
          w_count_next = '0;
          w_hit_next   = 1'b0;
        end else if (iFrameStart) begin
          w_min_x_next = w_new_min_x;
          w_max_x_next = w_new_max_x;
          w_min_y_next = w_new_min_y;
          w_max_y_next = w_new_max_y;
          w_count_next = w_new_count;
          w_hit_next   = w_match;
        end else begin
          w_min_x_next = w_cur_min_x;
          w_max_x_next = w_cur_max_x;
          w_min_y_next = w_cur_min_y;
          w_max_y_next = w_cur_max_y;
          w_count_next = w_cur_count;
          w_hit_next   = w_cur_hit;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_min_x <= '1;
      r_max_x <= '0;
      r_min_y <= '1;
      r_max_y <= '0;
      r_count <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_min_x <= w_min_x_next;
      r_max_x <= w_max_x_next;
      r_min_y <= w_min_y_next;
      r_max_y <= w_max_y_next;
      r_count <= w_count_next;
      r_hit   <= w_hit_next;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oDLeftX  <= '0;
      oDRightX <= '0;
      oDTopY   <= '0;
      oDUnderY <= '0;
      oCount   <= '0;
      oFound   <= 1'b0;
      oVd      <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      if (w_load) begin
        oDLeftX  <= w_cur_hit ? $signed({1'b0, w_cur_min_x}) : '0;
        oDRightX <= w_cur_hit ? $signed(w_right_x) : '0;
        oDTopY   <= w_cur_hit ? $signed({1'b0, w_cur_min_y}) : '0;
        oDUnderY <= w_cur_hit ? $signed(w_under_y) : '0;
        oCount   <= w_cur_hit ? w_cur_count : '0;
        oFound   <= w_cur_hit;
        oVd      <= 1'b1;
        if (oVd && !iRdy) oOverrun <= 1'b1;
      end else if (oVd && iRdy) begin
        oVd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_square_detect.sv
// Scoreboard bench for dot_square_detect: stimulus pushes hand-computed results,
// a monitor pops and compares each accepted result.
module tb_dot_square_detect;

  localparam logic [15:0] KEY   = 16'hF800;
  localparam logic [15:0] OTHER = 16'h07E0;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [15:0] iPixel, iKeyColor;
  logic [10:0] iHpos, iVpos;
  logic        iPixelVd, iFrameStart, iFrameEnd, iRdy;
  logic [11:0] oDLeftX, oDRightX, oDTopY, oDUnderY;
  logic [21:0] oCount;
  logic        oFound, oVd, oOverrun;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int l; int r; int t; int u; int c; int f;
  } exp_t;
  exp_t sb[$];

  dot_square_detect #(
    .pHdisplayWidth(11), .pVdisplayWidth(11), .pColorDepth(16)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iPixel(iPixel), .iKeyColor(iKeyColor),
    .iHpos(iHpos), .iVpos(iVpos), .iPixelVd(iPixelVd),
    .iFrameStart(iFrameStart), .iFrameEnd(iFrameEnd),
    .oDLeftX(oDLeftX), .oDRightX(oDRightX), .oDTopY(oDTopY), .oDUnderY(oDUnderY),
    .oCount(oCount), .oFound(oFound), .oVd(oVd), .iRdy(iRdy), .oOverrun(oOverrun)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int l, r, t, u, c, f);
    exp_t e;
    e.l = l; e.r = r; e.t = t; e.u = u; e.c = c; e.f = f;
    sb.push_back(e);
  endtask

  // Monitor: compare every result the consumer accepts
  always @(negedge iClk) begin
    if (!iRst && oVd && iRdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got left=%0d count=%0d, expected no result",
                 oDLeftX, oCount);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("left",  int'(oDLeftX),  e.l);
        check("right", int'(oDRightX), e.r);
        check("top",   int'(oDTopY),   e.t);
        check("under", int'(oDUnderY), e.u);
        check("count", int'(oCount),   e.c);
        check("found", int'(oFound),   e.f);
        $display("result: L=%0d R=%0d T=%0d U=%0d C=%0d F=%0d",
                 oDLeftX, oDRightX, oDTopY, oDUnderY, oCount, oFound);
      end
    end
  end

  task automatic cyc(input logic st, input logic en, input logic vd,
                     input logic [15:0] px, input int h, input int v);
    iFrameStart = st;
    iFrameEnd   = en;
    iPixelVd    = vd;
    iPixel      = px;
    iHpos       = h[10:0];
    iVpos       = v[10:0];
    @(posedge iClk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, OTHER, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst = 1'b1; iRdy = 1'b1; iKeyColor = KEY;
    iPixel = OTHER; iHpos = '0; iVpos = '0;
    iPixelVd = 1'b0; iFrameStart = 1'b0; iFrameEnd = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    iRst = 1'b0;
    check("rst_vd", int'(oVd), 0);
    check("rst_overrun", int'(oOverrun), 0);
    check("rst_found", int'(oFound), 0);
    check("rst_count", int'(oCount), 0);
    check("rst_right", int'(oDRightX), 0);

    // Pixels and frame end in IDLE must be ignored
    cyc(1'b0, 1'b1, 1'b1, KEY, 9, 9);
    idle(2);
    check("idle_no_vd", int'(oVd), 0);

    // 8x8 frame with three matches
    push_exp(2, 6, 3, 7, 3, 1);
    for (int v = 0; v < 8; v++)
      for (int h = 0; h < 8; h++) begin
        logic m;
        m = (h == 2 && v == 3) || (h == 5 && v == 3) || (h == 4 && v == 6);
        cyc(h == 0 && v == 0, h == 7 && v == 7, 1'b1, m ? KEY : OTHER, h, v);
        if (h == 7 && v == 7) check("latency_vd", int'(oVd), 1);
      end
    idle(3);

    // 8x8 frame, no match
    push_exp(0, 0, 0, 0, 0, 0);
    for (int v = 0; v < 8; v++)
      for (int h = 0; h < 8; h++)
        cyc(h == 0 && v == 0, h == 7 && v == 7, 1'b1, OTHER, h, v);
    idle(3);

    // Corner match at maximum coordinates
    push_exp(2047, 2048, 2047, 2048, 1, 1);
    cyc(1'b1, 1'b0, 1'b1, OTHER, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, KEY, 2047, 2047);
    idle(3);

    // Overrun: two results while consumer stalls; only the second is accepted
    iRdy = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, OTHER, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, KEY, 1, 2);
    idle(1);
    check("stall_overrun_clear", int'(oOverrun), 0);
    push_exp(3, 4, 3, 4, 1, 1);
    cyc(1'b1, 1'b0, 1'b1, OTHER, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, KEY, 3, 3);
    cyc(1'b0, 1'b1, 1'b1, OTHER, 4, 4);
    check("ovr_vd", int'(oVd), 1);
    check("ovr_flag", int'(oOverrun), 1);
    iRdy = 1'b1;
    idle(1);
    check("ovr_vd_drop", int'(oVd), 0);
    check("ovr_sticky", int'(oOverrun), 1);
    idle(2);

    // Restart mid-frame discards earlier matches
    push_exp(4, 5, 4, 5, 1, 1);
    cyc(1'b1, 1'b0, 1'b1, OTHER, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, KEY, 1, 1);
    cyc(1'b1, 1'b0, 1'b1, OTHER, 2, 2);
    check("restart_no_vd", int'(oVd), 0);
    cyc(1'b0, 1'b0, 1'b1, KEY, 4, 4);
    cyc(1'b0, 1'b1, 1'b1, OTHER, 5, 5);
    idle(3);

    // End and start together: matching pixel belongs to closing frame only
    push_exp(6, 7, 1, 2, 1, 1);
    push_exp(0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b1, OTHER, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, KEY, 6, 1);
    cyc(1'b0, 1'b0, 1'b1, OTHER, 1, 1);
    cyc(1'b0, 1'b1, 1'b1, OTHER, 2, 2);
    idle(3);

    // Matching pixel on the frame-start cycle is included
    push_exp(0, 1, 0, 1, 1, 1);
    cyc(1'b1, 1'b0, 1'b1, KEY, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, OTHER, 1, 0);
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    check("sb_drain", sb.size(), 0);
    check("overrun_before_rst", int'(oOverrun), 1);

    iRst = 1'b1;
    idle(1);
    iRst = 1'b0;
    check("overrun_after_rst", int'(oOverrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
